// File: rtl/nor_bus_cycle.sv
`timescale 1ns/1ps
// nor_bus_cycle: NOR flash bus sequencer for word write, word read and status polling.
// Flash strobes, address and data-enable are registered so the pins never glitch.
module nor_bus_cycle #(
  parameter int          T_WP     = 6,
  parameter int          T_ACC    = 12,
  parameter int          T_REC    = 3,
  parameter int          POLL_GAP = 100,
  parameter int unsigned POLL_MAX = 32'd500000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic [1:0]  OP,
  input  logic [23:0] REQ_ADDR,
  input  logic [15:0] REQ_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] RD_DATA,
  output logic        ERR,
  output logic        CE,
  output logic        WE,
  output logic        OE,
  output logic [23:0] ADDR,
  inout  wire  [15:0] DATA
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_W_SETUP = 3'd1;
  localparam logic [2:0] ST_W_PULSE = 3'd2;
  localparam logic [2:0] ST_W_HOLD  = 3'd3;
  localparam logic [2:0] ST_R_ACC   = 3'd4;
  localparam logic [2:0] ST_RECOVER = 3'd5;
  localparam logic [2:0] ST_P_GAP   = 3'd6;
  localparam logic [2:0] ST_FIN     = 3'd7;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  localparam int              CW         = 16;
  localparam logic [CW-1:0]   CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   WP_LOAD    = CW'(T_WP - 1);
  localparam logic [CW-1:0]   ACC_LOAD   = CW'(T_ACC - 1);
  localparam logic [CW-1:0]   REC_LOAD   = CW'(T_REC - 1);
  localparam logic [CW-1:0]   GAP_LOAD   = CW'(POLL_GAP - 1);
  localparam logic [31:0]     POLL_LIMIT = POLL_MAX;
  localparam logic [15:0]     STATUS_CMD = 16'h0070;

  logic [2:0]    state_r;
  logic [2:0]    state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [1:0]    op_r;
  logic [15:0]   wdata_r;
  logic [23:0]   addr_r;
  logic [15:0]   rd_data_r;
  logic          err_r;
  logic          err_s;
  logic          rd_seen_r;
  logic          rd_seen_s;
  logic [31:0]   poll_cnt_r;
  logic          busy_r;
  logic          done_r;
  logic          ce_r;
  logic          we_r;
  logic          oe_r;
  logic          drive_r;
  logic          ce_s;
  logic          we_s;
  logic          oe_s;
  logic          drive_s;
  logic          accept_s;
  logic          sample_s;
  logic          timeout_s;

  assign accept_s  = (state_r == ST_IDLE) && REQ;
  assign sample_s  = (state_r == ST_R_ACC) && (cnt_r == CNT_ZERO);
  assign timeout_s = (poll_cnt_r >= POLL_LIMIT);

  // Next-state, per-state cycle counter and completion status.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    err_s     = err_r;
    rd_seen_s = rd_seen_r;
    case (state_r)
      ST_IDLE: begin
        if (REQ) begin
          err_s     = 1'b0;
          rd_seen_s = 1'b0;
          case (OP)
            OP_WRITE, OP_POLL: begin
              state_s = ST_W_SETUP;
              cnt_s   = CNT_ZERO;
            end
            OP_READ: begin
              state_s = ST_R_ACC;
              cnt_s   = ACC_LOAD;
            end
            default: begin
              state_s = ST_FIN;
              cnt_s   = CNT_ZERO;
              err_s   = 1'b1;
            end
          endcase
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      ST_W_SETUP: begin
        state_s = ST_W_PULSE;
        cnt_s   = WP_LOAD;
      end
      ST_W_PULSE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_W_HOLD;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_W_HOLD: begin
        state_s = ST_RECOVER;
        cnt_s   = REC_LOAD;
      end
      ST_R_ACC: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_RECOVER;
          cnt_s   = REC_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RECOVER: begin
        // A poll's first RECOVER follows the 0x0070 write; later ones follow status reads.
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if (op_r != OP_POLL) begin
          state_s = ST_FIN;
        end else if (!rd_seen_r) begin
          state_s   = ST_R_ACC;
          cnt_s     = ACC_LOAD;
          rd_seen_s = 1'b1;
        end else if (rd_data_r[7]) begin
          state_s = ST_FIN;
        end else if (timeout_s) begin
          state_s = ST_FIN;
          err_s   = 1'b1;
        end else begin
          state_s = ST_P_GAP;
          cnt_s   = GAP_LOAD;
        end
      end
      ST_P_GAP: begin
        if (timeout_s) begin
          state_s = ST_FIN;
          cnt_s   = CNT_ZERO;
          err_s   = 1'b1;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = ST_R_ACC;
          cnt_s   = ACC_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Pin levels for the state being entered, so the registered strobes line up with it.
  always_comb begin
    ce_s    = 1'b1;
    we_s    = 1'b1;
    oe_s    = 1'b1;
    drive_s = 1'b0;
    case (state_s)
      ST_W_SETUP, ST_W_HOLD: begin
        ce_s    = 1'b0;
        drive_s = 1'b1;
      end
      ST_W_PULSE: begin
        ce_s    = 1'b0;
        we_s    = 1'b0;
        drive_s = 1'b1;
      end
      ST_R_ACC: begin
        ce_s = 1'b0;
        oe_s = 1'b0;
      end
      default: begin
        ce_s    = 1'b1;
        we_s    = 1'b1;
        oe_s    = 1'b1;
        drive_s = 1'b0;
      end
    endcase
  end

  // State, request capture, read sampling and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      op_r      <= 2'b00;
      wdata_r   <= 16'h0000;
      addr_r    <= 24'h000000;
      rd_data_r <= 16'h0000;
      err_r     <= 1'b0;
      rd_seen_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ce_r      <= 1'b1;
      we_r      <= 1'b1;
      oe_r      <= 1'b1;
      drive_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      err_r     <= err_s;
      rd_seen_r <= rd_seen_s;
      busy_r    <= (state_s != ST_IDLE);
      done_r    <= (state_s == ST_FIN);
      ce_r      <= ce_s;
      we_r      <= we_s;
      oe_r      <= oe_s;
      drive_r   <= drive_s;
      if (accept_s) begin
        op_r    <= OP;
        addr_r  <= REQ_ADDR;
        wdata_r <= (OP == OP_POLL) ? STATUS_CMD : REQ_DATA;
      end
      if (sample_s) begin
        rd_data_r <= DATA;
      end
    end
  end

  // Poll timeout: saturates at the limit so "reached" stays true until the poll ends.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      poll_cnt_r <= 32'd0;
    end else if (accept_s) begin
      poll_cnt_r <= 32'd0;
    end else if ((op_r == OP_POLL) && (state_r != ST_IDLE) && !timeout_s) begin
      poll_cnt_r <= poll_cnt_r + 32'd1;
    end else begin
      poll_cnt_r <= poll_cnt_r;
    end
  end

  assign DATA    = drive_r ? wdata_r : 16'hzzzz;
  assign BUSY    = busy_r;
  assign DONE    = done_r;
  assign RD_DATA = rd_data_r;
  assign ERR     = err_r;
  assign CE      = ce_r;
  assign WE      = we_r;
  assign OE      = oe_r;
  assign ADDR    = addr_r;

endmodule

// File: tb/tb_nor_bus_cycle.sv
`timescale 1ns/1ps
// Self-checking bench for nor_bus_cycle: random writes, reads and polls against
// cycle counts and values derived from the bus timing rules, plus reset and reserved-op cases.
module tb_nor_bus_cycle;

  localparam int T_WP     = 6;
  localparam int T_ACC    = 12;
  localparam int T_REC    = 3;
  localparam int POLL_GAP = 100;
  localparam int POLL_MAX = 2000;
  localparam int MAXC     = 4096;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        REQ = 1'b0;
  logic [1:0]  OP = 2'b00;
  logic [23:0] REQ_ADDR = 24'h000000;
  logic [15:0] REQ_DATA = 16'h0000;
  logic        BUSY;
  logic        DONE;
  logic [15:0] RD_DATA;
  logic        ERR;
  logic        CE;
  logic        WE;
  logic        OE;
  logic [23:0] ADDR;
  wire  [15:0] DATA;

  nor_bus_cycle #(
    .T_WP(T_WP), .T_ACC(T_ACC), .T_REC(T_REC), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .OP(OP), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .BUSY(BUSY), .DONE(DONE), .RD_DATA(RD_DATA), .ERR(ERR), .CE(CE), .WE(WE), .OE(OE),
    .ADDR(ADDR), .DATA(DATA)
  );

  always #5 CLK = ~CLK;

  // Flash model: answers each read cycle with the next word of rd_vals.
  logic [15:0] rd_vals [0:63];
  int          rd_cnt = 0;
  int          rd_base = 0;
  logic [5:0]  rd_sel;
  assign rd_sel = 6'(rd_cnt - rd_base);
  assign DATA   = (!CE && !OE) ? rd_vals[rd_sel] : 16'hzzzz;
  always @(posedge OE) rd_cnt <= rd_cnt + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_rd = 16'h0000;
  logic        ce_tr [0:MAXC-1];
  logic        we_tr [0:MAXC-1];
  logic        oe_tr [0:MAXC-1];
  logic        busy_tr [0:MAXC-1];
  logic [15:0] data_tr [0:MAXC-1];
  int          done_at;

  task automatic capture(input int budget);
    done_at = -1;
    for (int n = 1; n <= budget && n < MAXC; n++) begin
      @(negedge CLK);
      ce_tr[n] = CE; we_tr[n] = WE; oe_tr[n] = OE; busy_tr[n] = BUSY; data_tr[n] = DATA;
      if (DONE) begin
        done_at = n;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [23:0] a, input logic [15:0] d,
                        input int budget);
    @(negedge CLK);
    rd_base = rd_cnt;
    REQ = 1'b1; OP = op; REQ_ADDR = a; REQ_DATA = d;
    @(posedge CLK);
    #1;
    REQ = 1'b0; OP = 2'($urandom); REQ_ADDR = 24'($urandom); REQ_DATA = 16'($urandom);
    capture(budget);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp += 6;
    if (CE !== 1'b1 || WE !== 1'b1 || OE !== 1'b1) begin
      n_bad++; $display("FAIL reset_strobes: got CE=%b WE=%b OE=%b want 1 1 1", CE, WE, OE);
    end
    if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    if (DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", DONE); end
    if (ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", ERR); end
    if (RD_DATA !== 16'h0000) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0000", RD_DATA); end
    if (ADDR !== 24'h000000) begin n_bad++; $display("FAIL reset_addr: got %h want 000000", ADDR); end
    RESET = 1'b1;
    last_rd = 16'h0000;
  endtask

  task automatic test_write();
    for (int it = 0; it < 4; it++) begin
      logic [23:0] a;
      logic [15:0] d;
      int          lat;
      a   = (it == 0) ? 24'h3F0000 : 24'($urandom);
      d   = (it == 0) ? 16'h0060 : 16'($urandom);
      lat = 1 + T_WP + 1 + T_REC + 1;
      run_op(2'b00, a, d, 60);
      n_cmp++;
      if (done_at != lat) begin n_bad++; $display("FAIL write_latency: got %0d want %0d", done_at, lat); end
      for (int n = 1; n <= lat; n++) begin
        logic exp_ce, exp_we;
        exp_ce = !(n <= 1 + T_WP + 1);
        exp_we = !(n >= 2 && n <= 1 + T_WP);
        n_cmp += 3;
        if (ce_tr[n] !== exp_ce) begin n_bad++; $display("FAIL write_ce c%0d: got %b want %b", n, ce_tr[n], exp_ce); end
        if (we_tr[n] !== exp_we) begin n_bad++; $display("FAIL write_we c%0d: got %b want %b", n, we_tr[n], exp_we); end
        if (oe_tr[n] !== 1'b1) begin n_bad++; $display("FAIL write_oe c%0d: got %b want 1", n, oe_tr[n]); end
        if (!exp_ce) begin
          n_cmp++;
          if (data_tr[n] !== d) begin n_bad++; $display("FAIL write_data c%0d: got %h want %h", n, data_tr[n], d); end
        end
      end
      n_cmp += 3;
      if (ERR !== 1'b0) begin n_bad++; $display("FAIL write_err: got %b want 0", ERR); end
      if (RD_DATA !== last_rd) begin n_bad++; $display("FAIL write_rd_hold: got %h want %h", RD_DATA, last_rd); end
      if (ADDR !== a) begin n_bad++; $display("FAIL write_addr: got %h want %h", ADDR, a); end
    end
  endtask

  task automatic test_read();
    for (int it = 0; it < 4; it++) begin
      logic [23:0] a;
      logic [15:0] v;
      int          lat;
      a   = 24'($urandom);
      v   = (it == 0) ? 16'h0089 : 16'($urandom);
      lat = T_ACC + T_REC + 1;
      rd_vals[0] = v;
      run_op(2'b01, a, 16'($urandom), 60);
      n_cmp++;
      if (done_at != lat) begin n_bad++; $display("FAIL read_latency: got %0d want %0d", done_at, lat); end
      for (int n = 1; n <= lat; n++) begin
        logic exp_oe;
        exp_oe = !(n <= T_ACC);
        n_cmp += 3;
        if (oe_tr[n] !== exp_oe) begin n_bad++; $display("FAIL read_oe c%0d: got %b want %b", n, oe_tr[n], exp_oe); end
        if (ce_tr[n] !== exp_oe) begin n_bad++; $display("FAIL read_ce c%0d: got %b want %b", n, ce_tr[n], exp_oe); end
        if (we_tr[n] !== 1'b1) begin n_bad++; $display("FAIL read_we c%0d: got %b want 1", n, we_tr[n]); end
        if (!exp_oe) begin
          n_cmp++;
          if (data_tr[n] !== v) begin n_bad++; $display("FAIL read_bus c%0d: got %h want %h", n, data_tr[n], v); end
        end
      end
      n_cmp += 3;
      if (RD_DATA !== v) begin n_bad++; $display("FAIL read_rd_data: got %h want %h", RD_DATA, v); end
      if (ERR !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b want 0", ERR); end
      if (ADDR !== a) begin n_bad++; $display("FAIL read_addr: got %h want %h", ADDR, a); end
      last_rd = v;
    end
  endtask

  task automatic test_poll();
    for (int it = 0; it < 3; it++) begin
      int k, lat, wr_runs, rd_runs, gap, min_gap, lim;
      logic in_gap;
      k = (it == 0) ? 3 : int'($urandom_range(0, 4));
      for (int i = 0; i < k; i++) rd_vals[i] = (it == 0) ? 16'h0000 : (16'($urandom) & 16'hFF7F);
      rd_vals[k] = (it == 0) ? 16'h0080 : (16'($urandom) | 16'h0080);
      lat = (1 + T_WP + 1 + T_REC) + (k + 1) * (T_ACC + T_REC) + k * POLL_GAP + 1;
      run_op(2'b10, 24'($urandom), 16'($urandom), 2500);
      wr_runs = 0; rd_runs = 0; gap = 0; min_gap = 1 << 30; in_gap = 1'b0;
      lim = (done_at > 0) ? done_at : 0;
      for (int n = 1; n <= lim; n++) begin
        if (!we_tr[n] && (n == 1 || we_tr[n-1])) wr_runs++;
        if (!oe_tr[n] && (n == 1 || oe_tr[n-1])) begin
          if (in_gap && gap < min_gap) min_gap = gap;
          rd_runs++; in_gap = 1'b0;
        end
        if (oe_tr[n] && n > 1 && !oe_tr[n-1]) begin in_gap = 1'b1; gap = 0; end
        if (in_gap && ce_tr[n]) gap++;
        if (!we_tr[n]) begin
          n_cmp++;
          if (data_tr[n] !== 16'h0070) begin n_bad++; $display("FAIL poll_cmd c%0d: got %h want 0070", n, data_tr[n]); end
        end
      end
      n_cmp += 6;
      if (done_at != lat) begin n_bad++; $display("FAIL poll_latency k=%0d: got %0d want %0d", k, done_at, lat); end
      if (wr_runs != 1) begin n_bad++; $display("FAIL poll_writes: got %0d want 1", wr_runs); end
      if (rd_runs != k + 1) begin n_bad++; $display("FAIL poll_reads: got %0d want %0d", rd_runs, k + 1); end
      if (k > 0 && min_gap < POLL_GAP) begin n_bad++; $display("FAIL poll_gap: got %0d want >=%0d", min_gap, POLL_GAP); end
      if (RD_DATA !== rd_vals[k]) begin n_bad++; $display("FAIL poll_status: got %h want %h", RD_DATA, rd_vals[k]); end
      if (ERR !== 1'b0) begin n_bad++; $display("FAIL poll_err: got %b want 0", ERR); end
      last_rd = rd_vals[k];
    end
  endtask

  task automatic test_timeout();
    int nreads;
    logic [15:0] exp_rd;
    for (int i = 0; i < 64; i++) rd_vals[i] = 16'($urandom) & 16'hFF7F;
    run_op(2'b10, 24'($urandom), 16'($urandom), 2500);
    nreads = rd_cnt - rd_base;
    exp_rd = (nreads >= 1) ? rd_vals[6'(nreads - 1)] : 16'h0000;
    n_cmp += 5;
    if (done_at < 0) begin n_bad++; $display("FAIL timeout_done: got none want DONE"); end
    if (done_at >= 0 && done_at < POLL_MAX) begin n_bad++; $display("FAIL timeout_early: got %0d want >=%0d", done_at, POLL_MAX); end
    if (done_at > POLL_MAX + T_ACC + T_REC + 2) begin
      n_bad++; $display("FAIL timeout_late: got %0d want <=%0d", done_at, POLL_MAX + T_ACC + T_REC + 2);
    end
    if (ERR !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", ERR); end
    if (nreads < 2 || RD_DATA !== exp_rd) begin
      n_bad++; $display("FAIL timeout_status: got %h (reads %0d) want %h", RD_DATA, nreads, exp_rd);
    end
    last_rd = RD_DATA;
  endtask

  task automatic test_reserved();
    run_op(2'b11, 24'($urandom), 16'($urandom), 20);
    n_cmp += 3;
    if (done_at != 1) begin n_bad++; $display("FAIL rsv_latency: got %0d want 1", done_at); end
    if (ERR !== 1'b1) begin n_bad++; $display("FAIL rsv_err: got %b want 1", ERR); end
    if (done_at == 1 && (ce_tr[1] !== 1'b1 || we_tr[1] !== 1'b1 || oe_tr[1] !== 1'b1)) begin
      n_bad++; $display("FAIL rsv_bus: got CE=%b WE=%b OE=%b want 1 1 1", ce_tr[1], we_tr[1], oe_tr[1]);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2, we_low;
    logic err1, err2, quiet;
    n1 = -1; n2 = -1; we_low = 0; err1 = 1'b1; err2 = 1'b0; quiet = 1'b1;
    @(negedge CLK);
    REQ = 1'b1; OP = 2'b00; REQ_ADDR = 24'($urandom); REQ_DATA = 16'($urandom);
    @(posedge CLK);
    #1 OP = 2'b11;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      busy_tr[n] = BUSY;
      if (n1 < 0 && !WE) we_low++;
      if (n1 >= 0 && (!CE || !WE || !OE)) quiet = 1'b0;
      if (DONE && n1 < 0) begin
        n1 = n; err1 = ERR;
      end else if (DONE) begin
        n2 = n; err2 = ERR; REQ = 1'b0;
        break;
      end
    end
    REQ = 1'b0;
    n_cmp += 7;
    if (n1 != 1 + T_WP + 1 + T_REC + 1) begin n_bad++; $display("FAIL b2b_first_done: got %0d want %0d", n1, 1 + T_WP + 1 + T_REC + 1); end
    if (we_low != T_WP) begin n_bad++; $display("FAIL b2b_we_width: got %0d want %0d", we_low, T_WP); end
    if (err1 !== 1'b0) begin n_bad++; $display("FAIL b2b_first_err: got %b want 0", err1); end
    if (n1 > 0 && busy_tr[n1 + 1] !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_drop: got %b want 0", busy_tr[n1 + 1]); end
    if (n2 != n1 + 2) begin n_bad++; $display("FAIL b2b_second_done: got %0d want %0d", n2, n1 + 2); end
    if (err2 !== 1'b1) begin n_bad++; $display("FAIL b2b_second_err: got %b want 1", err2); end
    if (!quiet) begin n_bad++; $display("FAIL b2b_rsv_bus: got activity want CE/WE/OE=1"); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    logic        seen_done;
    @(negedge CLK);
    REQ = 1'b1; OP = 2'b00; REQ_ADDR = 24'($urandom); REQ_DATA = 16'($urandom);
    @(posedge CLK);
    #1 REQ = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (WE !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pre_we: got %b want 0", WE); end
    #2 RESET = 1'b0;
    #1;
    n_cmp += 4;
    if (WE !== 1'b1 || CE !== 1'b1) begin n_bad++; $display("FAIL rst_mid_strobes: got CE=%b WE=%b want 1 1", CE, WE); end
    if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", BUSY); end
    if (ADDR !== 24'h000000) begin n_bad++; $display("FAIL rst_mid_addr: got %h want 000000", ADDR); end
    if (RD_DATA !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_rd: got %h want 0000", RD_DATA); end
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (DONE) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done) begin n_bad++; $display("FAIL rst_mid_done: got pulse want none"); end
    v = 16'($urandom);
    rd_vals[0] = v;
    rd_base = rd_cnt;
    RESET = 1'b1; REQ = 1'b1; OP = 2'b01; REQ_ADDR = 24'($urandom);
    @(posedge CLK);
    #1 REQ = 1'b0;
    capture(60);
    n_cmp += 3;
    if (done_at != T_ACC + T_REC + 1) begin n_bad++; $display("FAIL rst_mid_read_lat: got %0d want %0d", done_at, T_ACC + T_REC + 1); end
    if (RD_DATA !== v) begin n_bad++; $display("FAIL rst_mid_read_data: got %h want %h", RD_DATA, v); end
    if (ERR !== 1'b0) begin n_bad++; $display("FAIL rst_mid_read_err: got %b want 0", ERR); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_poll();
    test_timeout();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nor_bus_cycle.md
NOR_BUS_CYCLE -- requirements
Module: nor_bus_cycle

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- T_WP, 6, WE low width in CLK cycles (60 ns at 100 MHz).
- T_ACC, 12, CE/OE low time before DATA is sampled on a read.
- T_REC, 3, CE high recovery cycles after every bus cycle.
- POLL_GAP, 100, CE high cycles between status re-reads.
- POLL_MAX, 500000000, poll timeout in cycles (5 s).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, single system clock, all logic on rising edge.
- RESET, in, 1, asynchronous, active-low reset.
- REQ, in, 1, request strobe.
- OP, in, 2, operation: 00 write word, 01 read word, 10 poll status, 11 reserved.
- REQ_ADDR, in, 24, flash word address.
- REQ_DATA, in, 16, write data (ignored for read and poll).
- BUSY, out, 1, operation in progress.
- DONE, out, 1, one-cycle completion pulse.
- RD_DATA, out, 16, read word or last status.
- ERR, out, 1, error flag, valid with DONE.
- CE, out, 1, flash chip enable, active-low.
- WE, out, 1, flash write enable, active-low.
- OE, out, 1, flash output enable, active-low.
- ADDR, out, 24, flash address.
- DATA, inout, 16, flash data bus.

Function
REQ-003 REQ SHALL be accepted only on a rising edge where BUSY=0; REQ while BUSY=1 SHALL be ignored and not queued.
REQ-004 On acceptance, OP, REQ_ADDR and REQ_DATA SHALL be registered; ADDR SHALL take REQ_ADDR and hold it until the next acceptance; BUSY SHALL be 1 from the following cycle.
REQ-005 States SHALL be IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACC, RECOVER, P_GAP, FIN.
REQ-006 Write cycle, in order:
- W_SETUP: 1 cycle, CE=0, WE=1, DATA driven.
- W_PULSE: T_WP cycles, CE=0, WE=0, DATA driven.
- W_HOLD: 1 cycle, CE=0, WE=1, DATA driven.
- RECOVER: T_REC cycles, CE=1, DATA released.
REQ-007 Read cycle: R_ACC holds CE=0, OE=0 for T_ACC cycles; DATA SHALL be sampled into RD_DATA on the last R_ACC cycle; the cycle then enters RECOVER.
REQ-008 DATA SHALL be driven only in W_SETUP, W_PULSE and W_HOLD, and SHALL be high-Z in every other state. OE=0 and DATA driven SHALL never coincide, and WE=0 and OE=0 SHALL never coincide.
REQ-009 Poll sequence:
- Issue a write cycle of 0x0070 to the registered address.
- Follow with read cycles.
- If the sampled DATA[7]=1, finish with ERR=0.
- Otherwise, after RECOVER, wait POLL_GAP cycles in P_GAP (CE=1), then read again without reissuing 0x0070.
REQ-010 The poll timeout counter SHALL be 32 bits, clear on acceptance, and increment every cycle of a poll operation. If it reaches POLL_MAX before DATA[7]=1, the block SHALL finish with ERR=1 and RD_DATA holding the last status read.
REQ-011 FIN SHALL last 1 cycle. In FIN, DONE=1, and BUSY SHALL be 0 from the next cycle; the next request is therefore accepted no earlier than 1 cycle after DONE.
REQ-012 Latency from the accepting edge to DONE:
- write: 1+T_WP+1+T_REC+1 cycles (12 with defaults).
- read: T_ACC+T_REC+1 cycles (16 with defaults).
REQ-013 OP=11 SHALL cause no bus activity (CE, WE, OE stay 1) and go directly to FIN with ERR=1.
REQ-014 ERR and RD_DATA SHALL hold their values until the next acceptance. For writes, ERR=0 and RD_DATA is unchanged.

Reset
REQ-015 RESET=0 SHALL asynchronously force:
- CE=WE=OE=1.
- DATA high-Z.
- BUSY=DONE=ERR=0, RD_DATA=0x0000, ADDR=0x000000.
- state IDLE, all counters 0.
REQ-016 RESET asserted mid-operation SHALL abort the operation immediately with no DONE pulse. The first request SHALL be accepted on the first rising edge after RESET returns to 1.

Verification
REQ-017 Write, REQ_ADDR=0x3F0000, REQ_DATA=0x0060 -> CE low 8 cycles, WE low exactly 6 cycles inside the CE-low window, DATA=0x0060 only while CE=0, DONE 12 cycles after acceptance.
REQ-018 Read, flash model returning 0x0089 -> OE low 12 cycles, RD_DATA=0x0089, ERR=0, DONE 16 cycles after acceptance, DATA never driven by the DUT.
REQ-019 Poll, model returning 0x0000 for 3 reads then 0x0080 -> one 0x0070 write, 4 reads separated by at least 100 CE-high cycles, RD_DATA=0x0080, ERR=0.
REQ-020 Poll with POLL_MAX=2000 and status stuck at 0x0000 -> DONE with ERR=1 within 2000 cycles plus one bus cycle of acceptance.
REQ-021 REQ held high during a write, then OP=11 -> the second request is accepted only after DONE; OP=11 gives DONE plus ERR=1 with CE, WE and OE constant 1.
REQ-022 RESET pulsed low during W_PULSE -> WE and CE go to 1 within the same cycle, DATA high-Z, no DONE; a new read after release completes normally.
